bullet_ctrl: RTL and testbench

- Single-bullet engine for one tank. It sits between the tank position/direction registers and the per-pixel colour mux of the VGA renderer.
- It takes a raw active-low fire button and the tank state, then launches a bullet from the barrel muzzle and advances it once per frame.
- It retires the bullet at the playfield border.
- It produces a registered per-pixel hit flag that the renderer ORs into its colour priority chain.

---
 rtl/bullet_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_bullet_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_ctrl.sv
// bullet_ctrl: single-bullet engine for one tank.
// Launches a bullet from the barrel muzzle on a synchronised fire press,
// advances it once per frame, retires it at the playfield border and
// produces a registered per-pixel hit flag for the renderer.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no bullet; a press arms pending, next frame_tick tries launch
// S_FLY    | bullet in flight, moves SPEED pixels per frame_tick
// S_COOL   | bullet retired, counting COOL_FRAMES frame_ticks before IDLE
module bullet_ctrl #(
  parameter int SPEED       = 4,
  parameter int BSIZE       = 4,
  parameter int COOL_FRAMES = 8,
  parameter int X_MIN       = 2,
  parameter int X_MAX       = 638,
  parameter int Y_MIN       = 1,
  parameter int Y_MAX       = 478
) (
  input  logic       clk_25m,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       fire_n,
  input  logic [9:0] tank_x,
  input  logic [9:0] tank_y,
  input  logic [1:0] tank_dir,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  output logic       bullet_active,
  output logic [9:0] bullet_x,
  output logic [9:0] bullet_y,
  output logic       bullet_pix,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_FLY, S_COOL} state_t;

  localparam int CW = (COOL_FRAMES > 1) ? $clog2(COOL_FRAMES + 1) : 1;

  // Positions are widened to signed so a move past row/column 0 shows up
  // as negative (illegal) instead of wrapping to a large legal value.
  localparam logic signed [11:0] C_BS    = 12'(BSIZE);
  localparam logic signed [11:0] C_SPEED = 12'(SPEED);
  localparam logic signed [11:0] C_XMIN  = 12'(X_MIN);
  localparam logic signed [11:0] C_XMAX  = 12'(X_MAX);
  localparam logic signed [11:0] C_YMIN  = 12'(Y_MIN);
  localparam logic signed [11:0] C_YMAX  = 12'(Y_MAX);
  localparam logic signed [11:0] C_MID   = 12'sd13;
  localparam logic signed [11:0] C_FAR   = 12'sd30;
  localparam logic [9:0]         C_BS10  = 10'(BSIZE);

  state_t        r_state;
  logic [1:0]    r_dir;
  logic          r_pending;
  logic [CW-1:0] r_cnt;

  logic       r_sync1;
  logic       r_sync2;
  logic       r_fire_d;
  logic [1:0] r_vld;
  logic       r_armed;

  logic               w_press;
  logic signed [11:0] w_tx;
  logic signed [11:0] w_ty;
  logic signed [11:0] w_bx;
  logic signed [11:0] w_by;
  logic signed [11:0] w_mx;
  logic signed [11:0] w_my;
  logic signed [11:0] w_nx;
  logic signed [11:0] w_ny;
  logic               w_launch_ok;
  logic               w_next_ok;
  logic [9:0]         w_dx;
  logic [9:0]         w_dy;

  function automatic logic box_ok(input logic signed [11:0] bx,
                                  input logic signed [11:0] by);
    return (bx >= C_XMIN) && (bx + C_BS - 12'sd1 <= C_XMAX) &&
           (by >= C_YMIN) && (by + C_BS - 12'sd1 <= C_YMAX);
  endfunction

  // Fire synchroniser and falling-edge detect. r_armed keeps a button held
  // through reset from counting as a press until it is seen released.
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_fire_d <= 1'b1;
      r_vld    <= 2'b00;
      r_armed  <= 1'b0;
    end else begin
      r_sync1  <= fire_n;
      r_sync2  <= r_sync1;
      r_fire_d <= r_sync2;
      r_vld    <= {r_vld[0], 1'b1};
      if (r_vld[1] && r_sync2) r_armed <= 1'b1;
    end
  end

  assign w_press = r_armed & r_fire_d & ~r_sync2;

  // Muzzle position from the live tank state and next position from the latched direction.
  always_comb begin
    w_tx = $signed({2'b00, tank_x});
    w_ty = $signed({2'b00, tank_y});
    w_bx = $signed({2'b00, bullet_x});
    w_by = $signed({2'b00, bullet_y});
    w_mx = w_tx + C_MID;
    w_my = w_ty - C_BS;
    case (tank_dir)
      2'd0: begin w_mx = w_tx + C_MID; w_my = w_ty - C_BS;  end
      2'd1: begin w_mx = w_tx + C_MID; w_my = w_ty + C_FAR; end
      2'd2: begin w_mx = w_tx - C_BS;  w_my = w_ty + C_MID; end
      default: begin w_mx = w_tx + C_FAR; w_my = w_ty + C_MID; end
    endcase
    w_nx = w_bx;
    w_ny = w_by;
    case (r_dir)
      2'd0: w_ny = w_by - C_SPEED;
      2'd1: w_ny = w_by + C_SPEED;
      2'd2: w_nx = w_bx - C_SPEED;
      default: w_nx = w_bx + C_SPEED;
    endcase
    w_launch_ok = box_ok(w_mx, w_my);
    w_next_ok   = box_ok(w_nx, w_ny);
    w_dx        = x_pos - bullet_x;
    w_dy        = y_pos - bullet_y;
  end

  // Bullet FSM with registered outputs and the registered pixel hit flag.
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_dir         <= 2'd0;
      r_pending     <= 1'b0;
      r_cnt         <= '0;
      bullet_active <= 1'b0;
      bullet_x      <= 10'd0;
      bullet_y      <= 10'd0;
      bullet_pix    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      bullet_pix <= bullet_active && (w_dx < C_BS10) && (w_dy < C_BS10);
      case (r_state)
        S_IDLE: begin
          if (frame_tick && r_pending && w_launch_ok) begin
            r_pending     <= 1'b0;
            bullet_x      <= w_mx[9:0];
            bullet_y      <= w_my[9:0];
            r_dir         <= tank_dir;
            bullet_active <= 1'b1;
            busy          <= 1'b1;
            r_state       <= S_FLY;
          end else if (frame_tick && r_pending) begin
            r_pending <= w_press;
          end else if (w_press) begin
            r_pending <= 1'b1;
          end
        end
        S_FLY: begin
          if (frame_tick) begin
            if (w_next_ok) begin
              bullet_x <= w_nx[9:0];
              bullet_y <= w_ny[9:0];
            end else begin
              bullet_active <= 1'b0;
              r_cnt         <= CW'(COOL_FRAMES);
              r_state       <= S_COOL;
            end
          end
        end
        S_COOL: begin
          if (frame_tick) begin
            if (r_cnt == '0) begin
              busy    <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bullet_ctrl.sv
// Testbench for bullet_ctrl: launch vector table, hand-written multi-cycle
// sequences and a randomised run against a frame-level reference model.
module tb_bullet_ctrl;

  localparam int SPEED = 4;
  localparam int BS    = 4;
  localparam int COOL  = 8;

  logic       clk_25m = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       fire_n = 1'b1;
  logic [9:0] tank_x = '0;
  logic [9:0] tank_y = '0;
  logic [1:0] tank_dir = '0;
  logic [9:0] x_pos = '0;
  logic [9:0] y_pos = '0;
  logic       bullet_active;
  logic [9:0] bullet_x;
  logic [9:0] bullet_y;
  logic       bullet_pix;
  logic       busy;

  bullet_ctrl dut (
    .clk_25m(clk_25m), .rst_n(rst_n), .frame_tick(frame_tick), .fire_n(fire_n),
    .tank_x(tank_x), .tank_y(tank_y), .tank_dir(tank_dir),
    .x_pos(x_pos), .y_pos(y_pos),
    .bullet_active(bullet_active), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .bullet_pix(bullet_pix), .busy(busy)
  );

  always #20 clk_25m = ~clk_25m;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int tx, ty, dir;
    int l_act, l_x, l_y;
    int n_act, n_x, n_y;
  } vec_t;
  vec_t vecs[13];

  // Reference model state, frame-level.
  int m_active, m_cooling, m_cool, m_pending, m_x, m_y, m_dir;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_25m);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    frame_tick = 1'b0;
    fire_n = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (4) step();
  endtask

  task automatic press();
    fire_n = 1'b0;
    repeat (5) step();
    fire_n = 1'b1;
    repeat (5) step();
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic set_tank(input int x, input int y, input int d);
    tank_x = 10'(x);
    tank_y = 10'(y);
    tank_dir = 2'(d);
  endtask

  function automatic bit in_field(input int x, input int y);
    return x >= 2 && x + BS - 1 <= 638 && y >= 1 && y + BS - 1 <= 478;
  endfunction

  task automatic model_press();
    if (!m_active && !m_cooling) m_pending = 1;
  endtask

  task automatic model_tick();
    int nx, ny;
    if (m_active != 0) begin
      nx = m_x + ((m_dir == 3) ? SPEED : (m_dir == 2) ? -SPEED : 0);
      ny = m_y + ((m_dir == 1) ? SPEED : (m_dir == 0) ? -SPEED : 0);
      if (in_field(nx, ny)) begin
        m_x = nx;
        m_y = ny;
      end else begin
        m_active = 0;
        m_cooling = 1;
        m_cool = COOL;
      end
    end else if (m_cooling != 0) begin
      if (m_cool == 0) m_cooling = 0;
      else m_cool--;
    end else if (m_pending != 0) begin
      int tx, ty, d;
      tx = int'(tank_x);
      ty = int'(tank_y);
      d  = int'(tank_dir);
      m_pending = 0;
      case (d)
        0: begin nx = tx + 13; ny = ty - BS; end
        1: begin nx = tx + 13; ny = ty + 30; end
        2: begin nx = tx - BS; ny = ty + 13; end
        default: begin nx = tx + 30; ny = ty + 13; end
      endcase
      if (in_field(nx, ny)) begin
        m_active = 1;
        m_x = nx;
        m_y = ny;
        m_dir = d;
      end
    end
  endtask

  initial begin
    vecs[0]  = '{100, 200, 0, 1, 113, 196, 1, 113, 192};
    vecs[1]  = '{100, 200, 1, 1, 113, 230, 1, 113, 234};
    vecs[2]  = '{100, 200, 2, 1,  96, 213, 1,  92, 213};
    vecs[3]  = '{100, 200, 3, 1, 130, 213, 1, 134, 213};
    vecs[4]  = '{609, 100, 3, 0,   0,   0, 0,   0,   0};
    vecs[5]  = '{  0,   5, 0, 1,  13,   1, 0,  13,   1};
    vecs[6]  = '{  6,  50, 2, 1,   2,  63, 0,   2,  63};
    vecs[7]  = '{  5,  50, 2, 0,   0,   0, 0,   0,   0};
    vecs[8]  = '{ 50, 445, 1, 1,  63, 475, 0,  63, 475};
    vecs[9]  = '{605,  50, 3, 1, 635,  63, 0, 635,  63};
    vecs[10] = '{100,   4, 0, 0,   0,   0, 0,   0,   0};
    vecs[11] = '{  2, 100, 2, 0,   0,   0, 0,   0,   0};
    vecs[12] = '{100, 448, 1, 0,   0,   0, 0,   0,   0};

    // Reset state
    do_reset();
    check("rst_active", int'(bullet_active), 0);
    check("rst_x", int'(bullet_x), 0);
    check("rst_y", int'(bullet_y), 0);
    check("rst_pix", int'(bullet_pix), 0);
    check("rst_busy", int'(busy), 0);

    // Launch table: each vector from reset, launch tick then one move tick
    for (int i = 0; i < 13; i++) begin
      do_reset();
      set_tank(vecs[i].tx, vecs[i].ty, vecs[i].dir);
      press();
      tick();
      check($sformatf("vec%0d_launch_act", i), int'(bullet_active), vecs[i].l_act);
      check($sformatf("vec%0d_launch_x", i), int'(bullet_x), vecs[i].l_x);
      check($sformatf("vec%0d_launch_y", i), int'(bullet_y), vecs[i].l_y);
      check($sformatf("vec%0d_launch_busy", i), int'(busy), vecs[i].l_act);
      tick();
      check($sformatf("vec%0d_move_act", i), int'(bullet_active), vecs[i].n_act);
      check($sformatf("vec%0d_move_x", i), int'(bullet_x), vecs[i].n_x);
      check($sformatf("vec%0d_move_y", i), int'(bullet_y), vecs[i].n_y);
    end

    // Flight to top border, cooldown, discarded presses
    do_reset();
    set_tank(100, 200, 0);
    press();
    tick();
    check("fly_launch_y", int'(bullet_y), 196);
    set_tank(300, 300, 3);
    for (int k = 1; k <= 48; k++) begin
      if (k == 10) press();
      tick();
      check($sformatf("fly_y_%0d", k), int'(bullet_y), 196 - 4 * k);
      check($sformatf("fly_act_%0d", k), int'(bullet_active), 1);
    end
    check("fly_x_held", int'(bullet_x), 113);
    tick();
    check("retire_act", int'(bullet_active), 0);
    check("retire_busy", int'(busy), 1);
    check("retire_y_hold", int'(bullet_y), 4);
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) press();
      tick();
      check($sformatf("cool_busy_%0d", k), int'(busy), 1);
    end
    tick();
    check("cool_done_busy", int'(busy), 0);
    set_tank(100, 200, 0);
    tick();
    check("discard_no_launch", int'(bullet_active), 0);
    press();
    tick();
    check("fresh_launch_act", int'(bullet_active), 1);
    check("fresh_launch_y", int'(bullet_y), 196);

    // Illegal muzzle clears pending
    do_reset();
    set_tank(609, 100, 3);
    press();
    tick();
    check("illegal_act", int'(bullet_active), 0);
    check("illegal_busy", int'(busy), 0);
    set_tank(100, 200, 0);
    tick();
    check("illegal_pending_cleared", int'(bullet_active), 0);

    // Press edge coincident with frame_tick
    do_reset();
    set_tank(100, 200, 0);
    fire_n = 1'b0;
    step();
    step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("same_cycle_no_launch", int'(bullet_active), 0);
    fire_n = 1'b1;
    repeat (5) step();
    tick();
    check("same_cycle_next_launch", int'(bullet_active), 1);
    check("same_cycle_next_y", int'(bullet_y), 196);

    // Button held through reset is ignored until re-pressed
    fire_n = 1'b0;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (6) step();
    set_tank(100, 200, 0);
    tick();
    check("held_reset_no_launch", int'(bullet_active), 0);
    fire_n = 1'b1;
    repeat (5) step();
    press();
    tick();
    check("held_reset_repress", int'(bullet_active), 1);

    // Pixel hit sweep around bullet at (200,50)
    do_reset();
    set_tank(187, 54, 0);
    press();
    tick();
    check("pix_bullet_x", int'(bullet_x), 200);
    check("pix_bullet_y", int'(bullet_y), 50);
    for (int yy = 48; yy <= 55; yy++) begin
      for (int xx = 198; xx <= 205; xx++) begin
        x_pos = 10'(xx);
        y_pos = 10'(yy);
        step();
        check($sformatf("pix_%0d_%0d", xx, yy), int'(bullet_pix),
              (xx >= 200 && xx <= 203 && yy >= 50 && yy <= 53) ? 1 : 0);
      end
    end

    // Reset mid-flight clears outputs without a clock edge
    x_pos = 10'd201;
    y_pos = 10'd51;
    step();
    check("pre_reset_pix", int'(bullet_pix), 1);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_active", int'(bullet_active), 0);
    check("midrst_x", int'(bullet_x), 0);
    check("midrst_y", int'(bullet_y), 0);
    check("midrst_pix", int'(bullet_pix), 0);
    check("midrst_busy", int'(busy), 0);
    step();
    rst_n = 1'b1;
    repeat (4) step();

    // Randomised run against the reference model
    m_active = 0; m_cooling = 0; m_cool = 0; m_pending = 0;
    m_x = 0; m_y = 0; m_dir = 0;
    for (int it = 0; it < 600; it++) begin
      int r, px, py;
      r = int'($urandom_range(0, 9));
      if (r < 3) begin
        press();
        model_press();
      end else begin
        set_tank(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
                 int'($urandom_range(0, 3)));
        tick();
        model_tick();
        check($sformatf("rnd%0d_act", it), int'(bullet_active), m_active);
        check($sformatf("rnd%0d_x", it), int'(bullet_x), m_x);
        check($sformatf("rnd%0d_y", it), int'(bullet_y), m_y);
        check($sformatf("rnd%0d_busy", it), int'(busy),
              (m_active != 0 || m_cooling != 0) ? 1 : 0);
        px = int'($urandom_range(0, 7)) + ((m_x >= 2) ? m_x - 2 : 0);
        py = int'($urandom_range(0, 7)) + ((m_y >= 2) ? m_y - 2 : 0);
        x_pos = 10'(px);
        y_pos = 10'(py);
        step();
        check($sformatf("rnd%0d_pix", it), int'(bullet_pix),
              (m_active != 0 && px >= m_x && px < m_x + BS &&
               py >= m_y && py < m_y + BS) ? 1 : 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
